maxnet_controller: RTL

MAXNET_CONTROLLER -- requirements
Module: maxnet_controller

---
 rtl/maxnet_controller_if.sv | 32 +++
 rtl/maxnet_controller.sv | 109 ++++++++++
 2 files changed

// File: rtl/maxnet_controller_if.sv
// Control/status bundle between a Maxnet datapath and its sequencer.
// slave = the controller, master = the datapath/host side driving it.
interface maxnet_controller_if #(
    parameter int N = 4
);
    localparam int WW = (N > 1) ? $clog2(N) : 1;

    logic          start;
    logic [N-1:0]  sign;
    logic [N-1:0]  nonzero;
    logic          sel_init;
    logic          ld_reg;
    logic [N-1:0]  ac_select;
    logic          busy;
    logic          done;
    logic [WW-1:0] winner;
    logic          winner_valid;
    logic [7:0]    iter_count;
    logic          timeout;

    modport master (
        output start, sign, nonzero,
        input  sel_init, ld_reg, ac_select, busy, done,
               winner, winner_valid, iter_count, timeout
    );

    modport slave (
        input  start, sign, nonzero,
        output sel_init, ld_reg, ac_select, busy, done,
               winner, winner_valid, iter_count, timeout
    );
endinterface

// File: rtl/maxnet_controller.sv
// Maxnet sequencer: INIT -> (CALC -> ACT -> CHECK)* -> DONE until at most one neuron survives.
// Optional iteration limit enabled by defining MAXNET_TIMEOUT_EN.
module maxnet_controller #(
    parameter int N        = 4,
    parameter int MAX_ITER = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    maxnet_controller_if.slave   bus
);
    localparam int WW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_CALC, S_ACT, S_CHECK, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [N-1:0]  ac_q;
    logic [WW-1:0] winner_q;
    logic          winner_valid_q;
    logic          timeout_q;
    logic [7:0]    iter_q;
    logic [CW-1:0] nz_cnt;
    logic [WW-1:0] nz_idx;
    logic          limit_hit;

    // Survivor count and index of the (highest) surviving neuron.
    always_comb begin
        nz_cnt = '0;
        nz_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.nonzero[i]) begin
                nz_cnt = nz_cnt + 1'b1;
                nz_idx = WW'(i);
            end
        end
    end

`ifdef MAXNET_TIMEOUT_EN
    assign limit_hit = (iter_q == 8'(MAX_ITER));
`else
    logic unused_max_iter;
    assign unused_max_iter = ^MAX_ITER;
    assign limit_hit       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_INIT;
            S_INIT:  state_nxt = S_CALC;
            S_CALC:  state_nxt = S_ACT;
            S_ACT:   state_nxt = S_CHECK;
            S_CHECK: state_nxt = (nz_cnt <= CW'(1) || limit_hit) ? S_DONE : S_CALC;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Result/status registers; all hold outside the states that update them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ac_q           <= '0;
            winner_q       <= '0;
            winner_valid_q <= 1'b0;
            timeout_q      <= 1'b0;
            iter_q         <= '0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    ac_q           <= '0;
                    winner_valid_q <= 1'b0;
                    timeout_q      <= 1'b0;
                    iter_q         <= '0;
                end
                S_CALC: ac_q <= bus.sign;
                S_CHECK: begin
                    if (nz_cnt <= CW'(1)) begin
                        winner_q       <= (nz_cnt == CW'(1)) ? nz_idx : '0;
                        winner_valid_q <= (nz_cnt == CW'(1));
                    end else if (limit_hit) begin
                        winner_q       <= '0;
                        winner_valid_q <= 1'b0;
                        timeout_q      <= 1'b1;
                    end else if (iter_q != 8'hFF) begin
                        iter_q <= iter_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sel_init     = (state == S_INIT);
    assign bus.ld_reg       = (state == S_INIT) || (state == S_ACT);
    assign bus.ac_select    = ac_q;
    assign bus.busy         = (state != S_IDLE);
    assign bus.done         = (state == S_DONE);
    assign bus.winner       = winner_q;
    assign bus.winner_valid = winner_valid_q;
    assign bus.iter_count   = iter_q;
    assign bus.timeout      = timeout_q;
endmodule
